hazard_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_unit_pkg.sv | 30 +++
 rtl/hazard_unit_if.sv | 43 ++++
 rtl/hazard_unit_fwd_sel.sv | 35 +++
 rtl/hazard_unit.sv | 104 ++++++++++
 tb/tb_hazard_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller: operand
// forward-select encodings and the source-priority helper.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_t;

    localparam int N_SRC  = 2;
    localparam int SRC_RS = 0;
    localparam int SRC_RT = 1;

    // Youngest in-flight writer wins: EX, then MEM, then WB.
    function automatic fwd_t prio_sel(input logic ex_hit, input logic mem_hit, input logic wb_hit);
        fwd_t sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of ID-stage sources, in-flight writers and hazard controls exchanged
// between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_mdu_start;
    logic          id_mdu_use;
    logic          ex_regwr;
    logic          ex_load;
    logic [AW-1:0] ex_rd;
    logic          mem_regwr;
    logic [AW-1:0] mem_rd;
    logic          wb_regwr;
    logic [AW-1:0] wb_rd;
    logic          br_taken;

    logic             stall_pc;
    logic             bubble_ex;
    logic             flush_ifid;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_start, id_mdu_use,
        output ex_regwr, ex_load, ex_rd, mem_regwr, mem_rd, wb_regwr, wb_rd, br_taken,
        input  stall_pc, bubble_ex, flush_ifid, fwd_a, fwd_b, mdu_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_start, id_mdu_use,
        input  ex_regwr, ex_load, ex_rd, mem_regwr, mem_rd, wb_regwr, wb_rd, br_taken,
        output stall_pc, bubble_ex, flush_ifid, fwd_a, fwd_b, mdu_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand comparator against the EX/MEM/WB writers plus the forward-select
// priority encoder; one instance per ID source register.
module hazard_unit_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int AW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic          ex_regwr,
    input  logic [AW-1:0] ex_rd,
    input  logic          mem_regwr,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_regwr,
    input  logic [AW-1:0] wb_rd,
    output logic          ex_hit,
    output logic          any_hit,
    output fwd_t          sel
);

    logic live;
    logic mem_hit;
    logic wb_hit;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    assign live    = use_src && (src != '0);
    assign ex_hit  = live && ex_regwr  && (ex_rd  == src);
    assign mem_hit = live && mem_regwr && (mem_rd == src);
    assign wb_hit  = live && wb_regwr  && (wb_rd  == src);
    assign any_hit = ex_hit || mem_hit || wb_hit;

    assign sel = (FWD_EN != 0) ? prio_sel(ex_hit, mem_hit, wb_hit) : FWD_RF;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: forward selects,
// load-use / MDU interlocks, branch flush, MDU busy tracking and stall counting.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int AW      = 5,
    parameter int FWD_EN  = 1,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    hazard_unit_if.slave hz
);

    // The issue cycle is the first occupied MDU cycle, so the counter only
    // covers the MDU_LAT-1 cycles that follow it.
    localparam int MDU_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    logic [AW-1:0]    src [N_SRC];
    logic [N_SRC-1:0] use_src;
    logic [N_SRC-1:0] ex_hit;
    logic [N_SRC-1:0] any_hit;
    fwd_t             sel [N_SRC];

    logic             load_use;
    logic             data_stall;
    logic             mdu_stall;
    logic             stall_pc;
    logic             mdu_accept;

    logic [MDU_W-1:0] mdu_cnt_d, mdu_cnt_q;
    logic             mdu_busy_d, mdu_busy_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    assign src[SRC_RS]     = hz.id_rs;
    assign src[SRC_RT]     = hz.id_rt;
    assign use_src[SRC_RS] = hz.id_use_rs;
    assign use_src[SRC_RT] = hz.id_use_rt;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fwd
            hazard_unit_fwd_sel #(
                .AW     (AW),
                .FWD_EN (FWD_EN)
            ) u_fwd_sel (
                .src       (src[gi]),
                .use_src   (use_src[gi]),
                .ex_regwr  (hz.ex_regwr),
                .ex_rd     (hz.ex_rd),
                .mem_regwr (hz.mem_regwr),
                .mem_rd    (hz.mem_rd),
                .wb_regwr  (hz.wb_regwr),
                .wb_rd     (hz.wb_rd),
                .ex_hit    (ex_hit[gi]),
                .any_hit   (any_hit[gi]),
                .sel       (sel[gi])
            );
        end
    endgenerate

    always_comb begin
        load_use   = hz.id_valid && hz.ex_load && (|ex_hit);
        // Without forwarding every in-flight dependency must drain before ID proceeds.
        data_stall = (FWD_EN != 0) ? load_use : (|any_hit);
        mdu_stall  = mdu_busy_q && (hz.id_mdu_use || hz.id_mdu_start);
        stall_pc   = !reset && !hz.br_taken && (data_stall || mdu_stall);
        mdu_accept = hz.id_valid && hz.id_mdu_start && !stall_pc && !hz.br_taken;

        mdu_cnt_d = mdu_cnt_q;
        if (mdu_accept) begin
            mdu_cnt_d = MDU_W'(MDU_LAT - 1);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
        end
        mdu_busy_d = (mdu_cnt_d != '0);

        stall_cnt_d = stall_cnt_q;
        if (stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_q   <= '0;
            mdu_busy_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            mdu_busy_q  <= mdu_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_pc   = stall_pc;
    assign hz.bubble_ex  = !reset && (hz.br_taken || data_stall || mdu_stall);
    assign hz.flush_ifid = !reset && hz.br_taken;
    assign hz.fwd_a      = reset ? FWD_RF : sel[SRC_RS];
    assign hz.fwd_b      = reset ? FWD_RF : sel[SRC_RT];
    assign hz.mdu_busy   = mdu_busy_q;
    assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a table of combinational vectors plus
// hand-written MDU, reset and saturation sequences on three configurations.
module tb_hazard_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [34:0] in_bus;

    hazard_unit_if #(.AW(5), .CNT_W(16)) if_m ();
    hazard_unit_if #(.AW(5), .CNT_W(16)) if_n ();
    hazard_unit_if #(.AW(5), .CNT_W(4))  if_s ();

    assign {if_m.id_valid, if_m.id_rs, if_m.id_rt, if_m.id_use_rs, if_m.id_use_rt,
            if_m.id_mdu_start, if_m.id_mdu_use, if_m.ex_regwr, if_m.ex_load, if_m.ex_rd,
            if_m.mem_regwr, if_m.mem_rd, if_m.wb_regwr, if_m.wb_rd, if_m.br_taken} = in_bus;
    assign {if_n.id_valid, if_n.id_rs, if_n.id_rt, if_n.id_use_rs, if_n.id_use_rt,
            if_n.id_mdu_start, if_n.id_mdu_use, if_n.ex_regwr, if_n.ex_load, if_n.ex_rd,
            if_n.mem_regwr, if_n.mem_rd, if_n.wb_regwr, if_n.wb_rd, if_n.br_taken} = in_bus;
    assign {if_s.id_valid, if_s.id_rs, if_s.id_rt, if_s.id_use_rs, if_s.id_use_rt,
            if_s.id_mdu_start, if_s.id_mdu_use, if_s.ex_regwr, if_s.ex_load, if_s.ex_rd,
            if_s.mem_regwr, if_s.mem_rd, if_s.wb_regwr, if_s.wb_rd, if_s.br_taken} = in_bus;

    hazard_unit #(.AW(5), .FWD_EN(1), .MDU_LAT(4), .CNT_W(16)) dut_m (.clk(clk), .reset(reset), .hz(if_m));
    hazard_unit #(.AW(5), .FWD_EN(0), .MDU_LAT(4), .CNT_W(16)) dut_n (.clk(clk), .reset(reset), .hz(if_n));
    hazard_unit #(.AW(5), .FWD_EN(1), .MDU_LAT(4), .CNT_W(4))  dut_s (.clk(clk), .reset(reset), .hz(if_s));

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       ex_regwr;
        logic       ex_load;
        logic [4:0] ex_rd;
        logic       mem_regwr;
        logic [4:0] mem_rd;
        logic       wb_regwr;
        logic [4:0] wb_rd;
        logic       br;
        logic       e_stall;
        logic       e_bubble;
        logic       e_flush;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic       e_nstall;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    vec_t idle;
    vec_t br_idle;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic ms, input logic mu);
        in_bus = {v.valid, v.rs, v.rt, v.use_rs, v.use_rt, ms, mu, v.ex_regwr, v.ex_load,
                  v.ex_rd, v.mem_regwr, v.mem_rd, v.wb_regwr, v.wb_rd, v.br};
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        drive(idle, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //            vld rs    rt    urs   urt   exw   exl   exrd  memw  memrd wbw   wbrd  br   | st   bub  fl   a      b      nst
        vecs[0]  = '{1'b1,5'd3,5'd0,1'b1,1'b0,1'b1,1'b0,5'd3,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b01,2'b00,1'b1};
        vecs[1]  = '{1'b1,5'd3,5'd0,1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,5'd3,1'b1,5'd3,1'b0, 1'b0,1'b0,1'b0,2'b10,2'b00,1'b1};
        vecs[2]  = '{1'b1,5'd0,5'd0,1'b0,1'b1,1'b1,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
        vecs[3]  = '{1'b1,5'd0,5'd5,1'b0,1'b1,1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b0,2'b00,2'b01,1'b1};
        vecs[4]  = '{1'b1,5'd0,5'd5,1'b0,1'b1,1'b0,1'b0,5'd0,1'b1,5'd5,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b10,1'b1};
        vecs[5]  = '{1'b1,5'd0,5'd5,1'b0,1'b1,1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0,1'b1, 1'b0,1'b1,1'b1,2'b00,2'b01,1'b0};
        vecs[6]  = '{1'b1,5'd7,5'd0,1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,5'd0,1'b1,5'd7,1'b0, 1'b0,1'b0,1'b0,2'b11,2'b00,1'b1};
        vecs[7]  = '{1'b1,5'd0,5'd9,1'b0,1'b1,1'b0,1'b0,5'd0,1'b0,5'd0,1'b1,5'd9,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b11,1'b1};
        vecs[8]  = '{1'b1,5'd4,5'd6,1'b1,1'b1,1'b1,1'b0,5'd4,1'b1,5'd6,1'b1,5'd4,1'b0, 1'b0,1'b0,1'b0,2'b01,2'b10,1'b1};
        vecs[9]  = '{1'b1,5'd3,5'd0,1'b0,1'b0,1'b1,1'b0,5'd3,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
        vecs[10] = '{1'b0,5'd0,5'd5,1'b0,1'b1,1'b1,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b01,1'b1};
        vecs[11] = '{1'b1,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b1, 1'b0,1'b1,1'b1,2'b00,2'b00,1'b0};
        vecs[12] = '{1'b1,5'd0,5'd5,1'b0,1'b1,1'b0,1'b1,5'd5,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
        vecs[13] = '{1'b1,5'd2,5'd8,1'b1,1'b1,1'b1,1'b1,5'd2,1'b1,5'd8,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b0,2'b01,2'b10,1'b1};
        idle     = '{1'b1,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
        br_idle  = idle;
        br_idle.br = 1'b1;

        // Reset: combinational outputs forced low even with a flush+hazard present.
        reset = 1'b1;
        drive(vecs[5], 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall",  32'(if_m.stall_pc),   32'd0);
        chk("rst_bubble", 32'(if_m.bubble_ex),  32'd0);
        chk("rst_flush",  32'(if_m.flush_ifid), 32'd0);
        chk("rst_fwd_b",  32'(if_m.fwd_b),      32'd0);
        chk("rst_cnt",    32'(if_m.stall_cnt),  32'd0);
        chk("rst_busy",   32'(if_m.mdu_busy),   32'd0);
        $display("reset: stall=%0d bubble=%0d flush=%0d cnt=%0d", if_m.stall_pc, if_m.bubble_ex, if_m.flush_ifid, if_m.stall_cnt);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b0, 1'b0);
            #1;
            chk($sformatf("v%0d_stall", i),   32'(if_m.stall_pc),   32'(vecs[i].e_stall));
            chk($sformatf("v%0d_bubble", i),  32'(if_m.bubble_ex),  32'(vecs[i].e_bubble));
            chk($sformatf("v%0d_flush", i),   32'(if_m.flush_ifid), 32'(vecs[i].e_flush));
            chk($sformatf("v%0d_fwd_a", i),   32'(if_m.fwd_a),      32'(vecs[i].e_a));
            chk($sformatf("v%0d_fwd_b", i),   32'(if_m.fwd_b),      32'(vecs[i].e_b));
            chk($sformatf("v%0d_n_stall", i), 32'(if_n.stall_pc),   32'(vecs[i].e_nstall));
            chk($sformatf("v%0d_n_bub", i),   32'(if_n.bubble_ex),  32'(vecs[i].e_nstall | vecs[i].br));
            chk($sformatf("v%0d_n_fwd", i),   32'({if_n.fwd_a, if_n.fwd_b}), 32'd0);
            $display("vec %0d: stall=%0d bubble=%0d flush=%0d fwd_a=%0d fwd_b=%0d nofwd_stall=%0d",
                     i, if_m.stall_pc, if_m.bubble_ex, if_m.flush_ifid, if_m.fwd_a, if_m.fwd_b, if_n.stall_pc);
        end

        // MDU: start at cycle 0, mfhi from cycle 1; stalls on cycles 1-3.
        reset_pulse();
        @(negedge clk);
        drive(idle, 1'b1, 1'b0);
        #1;
        chk("mdu_c0_stall", 32'(if_m.stall_pc), 32'd0);
        chk("mdu_c0_busy",  32'(if_m.mdu_busy), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(idle, 1'b0, 1'b1);
            #1;
            chk($sformatf("mdu_c%0d_stall", c),  32'(if_m.stall_pc),  32'(c < 4));
            chk($sformatf("mdu_c%0d_bubble", c), 32'(if_m.bubble_ex), 32'(c < 4));
            chk($sformatf("mdu_c%0d_busy", c),   32'(if_m.mdu_busy),  32'(c < 4));
            $display("mdu cycle %0d: stall=%0d busy=%0d cnt=%0d", c, if_m.stall_pc, if_m.mdu_busy, if_m.stall_cnt);
        end
        chk("mdu_stall_cnt", 32'(if_m.stall_cnt), 32'd3);

        // New start while busy stalls; reset mid-MDU clears busy and stall_cnt.
        @(negedge clk);
        drive(idle, 1'b1, 1'b0);
        @(negedge clk);
        drive(idle, 1'b1, 1'b0);
        #1;
        chk("mdu_restart_stall", 32'(if_m.stall_pc), 32'd1);
        chk("mdu_restart_busy",  32'(if_m.mdu_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive(idle, 1'b0, 1'b1);
        #1;
        chk("mdu_pre_rst_cnt",   32'(if_m.stall_cnt), 32'd4);
        chk("mdu_in_rst_stall",  32'(if_m.stall_pc),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(idle, 1'b0, 1'b0);
        #1;
        chk("mdu_post_rst_busy", 32'(if_m.mdu_busy),  32'd0);
        chk("mdu_post_rst_cnt",  32'(if_m.stall_cnt), 32'd0);
        $display("mdu reset: busy=%0d cnt=%0d", if_m.mdu_busy, if_m.stall_cnt);

        // A taken branch squashes the MDU start; so does an invalid ID slot.
        @(negedge clk);
        drive(br_idle, 1'b1, 1'b0);
        #1;
        chk("br_start_flush", 32'(if_m.flush_ifid), 32'd1);
        @(negedge clk);
        idle.valid = 1'b0;
        drive(idle, 1'b1, 1'b0);
        idle.valid = 1'b1;
        #1;
        chk("br_start_busy", 32'(if_m.mdu_busy), 32'd0);
        @(negedge clk);
        drive(idle, 1'b0, 1'b0);
        #1;
        chk("inv_start_busy", 32'(if_m.mdu_busy), 32'd0);
        $display("squashed starts: busy=%0d", if_m.mdu_busy);

        // Saturation: 20 held stall cycles.
        reset_pulse();
        @(negedge clk);
        drive(vecs[3], 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat_cnt_w4",  32'(if_s.stall_cnt), 32'd15);
        chk("sat_cnt_w16", 32'(if_m.stall_cnt), 32'd20);
        chk("sat_cnt_nof", 32'(if_n.stall_cnt), 32'd20);
        $display("saturation: cnt4=%0d cnt16=%0d", if_s.stall_cnt, if_m.stall_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
